// File: rtl/move_entry_ctrl.sv
// move_entry_ctrl
//   Front-end for the tic-tac-toe board. Five raw push-buttons are
//   synchronised and debounced; the direction buttons steer a wrap-around
//   3x3 cursor and the select button requests a move at the cursor. Legal
//   moves are issued to the board as a one-cycle set strobe and confirmed
//   by watching the board's occupancy vector; illegal moves and moves the
//   board never confirms produce a one-cycle reject pulse.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   btn_up/down/left/right  raw cursor buttons, active-high, asynchronous
//   btn_sel                 raw confirm button
//   board_valid[8:0]        cell occupancy, bit = row*3+col
//   game_state[1:0]         00 playing, 01/10 win, 11 draw
//   cur_row/cur_col         cursor position, 0..2
//   set, row, col           one-cycle move strobe with latched target
//   busy                    a move is being issued or awaiting confirmation
//   reject                  one-cycle pulse: illegal move or no confirmation
//   move_count              confirmed moves since reset, saturates at 9
module move_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic [8:0] board_valid,
  input  logic [1:0] game_state,
  output logic [1:0] cur_row,
  output logic [1:0] cur_col,
  output logic       set,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       busy,
  output logic       reject,
  output logic [3:0] move_count
);

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4;
  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} * 4'd3) + {2'b00, c};
  endfunction

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] wrap_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
  endfunction

  logic [4:0]      btn_raw;
  logic [4:0]      sync1_q, sync2_q;
  logic [4:0]      db_q, db_d;
  logic [4:0]      evt_q, evt_d;
  logic [4:0][7:0] dbc_q, dbc_d;
  logic [1:0]      cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  state_t          state_q, state_d;
  logic [1:0]      row_q, row_d, col_q, col_d;
  logic            reject_q, reject_d;
  logic [3:0]      ack_cnt_q, ack_cnt_d;
  logic [3:0]      move_cnt_q, move_cnt_d;
  logic [15:0]     valid_ext;
  logic [3:0]      cur_idx, tgt_idx;

  assign btn_raw   = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign valid_ext = {7'd0, board_valid};
  assign cur_idx   = cell_idx(cur_row_q, cur_col_q);
  assign tgt_idx   = cell_idx(row_q, col_q);

  // Debounce stage: a level must disagree with the debounced state for
  // DEBOUNCE_CYCLES consecutive samples before it is accepted.
  always_comb begin
    db_d  = db_q;
    dbc_d = dbc_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          db_d[i]  = ~db_q[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + 8'd1;
        end
      end else begin
        dbc_d[i] = '0;
      end
    end
    evt_d = db_d & ~db_q;
  end

  // Cursor stage: opposing events in one cycle cancel; row and column
  // axes are independent.
  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    if (evt_q[B_UP] && !evt_q[B_DOWN])         cur_row_d = wrap_dec(cur_row_q);
    else if (evt_q[B_DOWN] && !evt_q[B_UP])    cur_row_d = wrap_inc(cur_row_q);
    if (evt_q[B_LEFT] && !evt_q[B_RIGHT])      cur_col_d = wrap_dec(cur_col_q);
    else if (evt_q[B_RIGHT] && !evt_q[B_LEFT]) cur_col_d = wrap_inc(cur_col_q);
  end

  // Move FSM stage
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    reject_d   = 1'b0;
    ack_cnt_d  = ack_cnt_q;
    move_cnt_d = move_cnt_q;
    case (state_q)
      IDLE: begin
        if (evt_q[B_SEL]) begin
          if ((game_state != 2'b00) || valid_ext[cur_idx]) begin
            reject_d = 1'b1;
          end else begin
            row_d   = cur_row_q;
            col_d   = cur_col_q;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        ack_cnt_d = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        // game_state is deliberately not consulted: the board decides.
        if (valid_ext[tgt_idx]) begin
          if (move_cnt_q != 4'd9) move_cnt_d = move_cnt_q + 4'd1;
          state_d = IDLE;
        end else if (ack_cnt_q == ACK_LAST) begin
          reject_d = 1'b1;
          state_d  = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      dbc_q      <= '0;
      evt_q      <= '0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      reject_q   <= 1'b0;
      ack_cnt_q  <= '0;
      move_cnt_q <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      dbc_q      <= dbc_d;
      evt_q      <= evt_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      reject_q   <= reject_d;
      ack_cnt_q  <= ack_cnt_d;
      move_cnt_q <= move_cnt_d;
    end
  end

  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;
  assign set        = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign row        = row_q;
  assign col        = col_q;
  assign reject     = reject_q;
  assign move_count = move_cnt_q;

endmodule

// File: tb/tb_move_entry_ctrl.sv
module tb_move_entry_ctrl;
  localparam int DB  = 4;
  localparam int TO  = 4;
  // Raw button driven at a falling edge -> visible effect: 2 sync flops,
  // DB agreeing samples, then the registered cursor/FSM output.
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;   // 0 up, 1 down, 2 left, 3 right, 4 sel
  logic [8:0] board_valid;
  logic [1:0] game_state;
  logic [1:0] cur_row, cur_col, row, col;
  logic       set, busy, reject;
  logic [3:0] move_count;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       is_set;
    logic [1:0] r;
    logic [1:0] c;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  move_entry_ctrl #(.DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]),
    .btn_right(btn[3]), .btn_sel(btn[4]),
    .board_valid(board_valid), .game_state(game_state),
    .cur_row(cur_row), .cur_col(cur_col), .set(set), .row(row), .col(col),
    .busy(busy), .reject(reject), .move_count(move_count)
  );

  // Scoreboard: every set/reject strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (set || reject)) begin
      checks++;
      if (set && reject) begin
        $display("FAIL sb_exclusive: set=%b reject=%b, required not both", set, reject);
      end else if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected: set=%b reject=%b row=%0d col=%0d, required no strobe",
                 set, reject, row, col);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.is_set) begin
          if ({set, row, col} !== {1'b1, mon_e.r, mon_e.c})
            $display("FAIL sb_set: set=%b row=%0d col=%0d, required set=1 row=%0d col=%0d",
                     set, row, col, mon_e.r, mon_e.c);
          else passed++;
        end else begin
          if ({set, reject} !== 2'b01)
            $display("FAIL sb_reject: set=%b reject=%b, required set=0 reject=1", set, reject);
          else passed++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press and release a set of buttons, leaving time for both debounces.
  task automatic press(input logic [4:0] mask);
    btn = btn | mask;
    tick(10);
    btn = btn & ~mask;
    tick(10);
  endtask

  // Count falling edges until set or reject is seen; -1 if none in budget.
  task automatic wait_strobe(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (set || reject) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; btn = '0; board_valid = '0; game_state = 2'b00;
    tick(3);
    checks++;
    if ({cur_row, cur_col, set, row, col, busy, reject, move_count} !== 15'd0)
      $display("FAIL reset_outputs: got %h, required 0",
               {cur_row, cur_col, set, row, col, busy, reject, move_count});
    else passed++;
    reset = 1'b0;
    tick(3);
    checks++;
    if ({cur_row, cur_col, busy, move_count} !== 9'd0)
      $display("FAIL reset_idle: got %h, required 0", {cur_row, cur_col, busy, move_count});
    else passed++;
  endtask

  task automatic test_debounce;
    int first;
    first = -1;
    btn[3] = 1'b1; tick(1);
    btn[3] = 1'b0; tick(1);
    btn[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (first < 0 && cur_col != 2'd0) first = k;
    end
    btn[3] = 1'b0;
    checks++;
    if (first !== LAT) $display("FAIL debounce_latency: cursor moved at cycle %0d, required %0d", first, LAT);
    else passed++;
    tick(12);
    checks++;
    if ({cur_row, cur_col} !== {2'd0, 2'd1})
      $display("FAIL debounce_single: cursor (%0d,%0d), required (0,1)", cur_row, cur_col);
    else passed++;
  endtask

  task automatic test_wrap;
    logic [1:0] exp_rows [3];
    exp_rows[0] = 2'd2; exp_rows[1] = 2'd1; exp_rows[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      press(5'b00001);
      checks++;
      if (cur_row !== exp_rows[i])
        $display("FAIL wrap_up%0d: cur_row=%0d, required %0d", i, cur_row, exp_rows[i]);
      else passed++;
    end
    press(5'b00011);
    checks++;
    if ({cur_row, cur_col} !== {2'd0, 2'd1})
      $display("FAIL wrap_cancel: cursor (%0d,%0d), required (0,1)", cur_row, cur_col);
    else passed++;
  endtask

  task automatic test_legal;
    int cyc;
    press(5'b00010);
    press(5'b01000);
    checks++;
    if ({cur_row, cur_col} !== {2'd1, 2'd2})
      $display("FAIL legal_cursor: cursor (%0d,%0d), required (1,2)", cur_row, cur_col);
    else passed++;
    board_valid = '0;
    sbq.push_back('{is_set: 1'b1, r: 2'd1, c: 2'd2});
    btn[4] = 1'b1;
    wait_strobe(cyc);
    checks++;
    if (cyc !== LAT || set !== 1'b1 || busy !== 1'b1)
      $display("FAIL legal_set: cycle=%0d set=%b busy=%b, required cycle=%0d set=1 busy=1",
               cyc, set, busy, LAT);
    else passed++;
    board_valid = 9'h020;
    tick(1);
    checks++;
    if (set !== 1'b0 || busy !== 1'b1)
      $display("FAIL legal_one_cycle: set=%b busy=%b, required set=0 busy=1", set, busy);
    else passed++;
    tick(1);
    checks++;
    if (move_count !== 4'd1 || busy !== 1'b0)
      $display("FAIL legal_ack: move_count=%0d busy=%b, required 1 and 0", move_count, busy);
    else passed++;
    btn[4] = 1'b0;
    tick(12);
  endtask

  task automatic test_occupied;
    int cyc, any_set;
    press(5'b00100);
    board_valid = 9'h030;
    sbq.push_back('{is_set: 1'b0, r: 2'd0, c: 2'd0});
    btn[4] = 1'b1;
    wait_strobe(cyc);
    checks++;
    if (cyc !== LAT || reject !== 1'b1 || set !== 1'b0)
      $display("FAIL occupied_reject: cycle=%0d reject=%b set=%b, required cycle=%0d reject=1 set=0",
               cyc, reject, set, LAT);
    else passed++;
    any_set = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (set || reject || busy) any_set++;
    end
    checks++;
    if (any_set !== 0 || move_count !== 4'd1)
      $display("FAIL occupied_quiet: extra strobes=%0d move_count=%0d, required 0 and 1",
               any_set, move_count);
    else passed++;
    btn[4] = 1'b0;
    tick(12);
  endtask

  task automatic test_game_over;
    int cyc;
    board_valid = '0;
    game_state  = 2'b10;
    sbq.push_back('{is_set: 1'b0, r: 2'd0, c: 2'd0});
    btn[4] = 1'b1;
    wait_strobe(cyc);
    checks++;
    if (cyc !== LAT || reject !== 1'b1 || set !== 1'b0 || busy !== 1'b0)
      $display("FAIL gameover_reject: cycle=%0d reject=%b set=%b busy=%b, required %0d,1,0,0",
               cyc, reject, set, busy, LAT);
    else passed++;
    btn[4] = 1'b0;
    tick(12);
    game_state = 2'b00;
  endtask

  task automatic test_timeout;
    int cyc, rcyc;
    board_valid = '0;
    sbq.push_back('{is_set: 1'b1, r: 2'd1, c: 2'd1});
    sbq.push_back('{is_set: 1'b0, r: 2'd0, c: 2'd0});
    btn[4] = 1'b1;
    wait_strobe(cyc);
    checks++;
    if (cyc !== LAT || set !== 1'b1)
      $display("FAIL timeout_set: cycle=%0d set=%b, required %0d and 1", cyc, set, LAT);
    else passed++;
    wait_strobe(rcyc);
    checks++;
    if (rcyc !== TO + 1 || reject !== 1'b1 || busy !== 1'b0 || move_count !== 4'd1)
      $display("FAIL timeout_reject: after %0d cycles reject=%b busy=%b count=%0d, required %0d,1,0,1",
               rcyc, reject, busy, move_count, TO + 1);
    else passed++;
    btn[4] = 1'b0;
    tick(12);
  endtask

  task automatic test_reset_mid;
    int cyc;
    board_valid = '0;
    sbq.push_back('{is_set: 1'b1, r: 2'd1, c: 2'd1});
    btn[4] = 1'b1;
    wait_strobe(cyc);
    tick(1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cur_row, cur_col, set, row, col, busy, reject, move_count} !== 15'd0)
      $display("FAIL reset_mid_async: got %h, required 0",
               {cur_row, cur_col, set, row, col, busy, reject, move_count});
    else passed++;
    btn[4] = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);
    sbq.push_back('{is_set: 1'b1, r: 2'd0, c: 2'd0});
    btn[4] = 1'b1;
    wait_strobe(cyc);
    checks++;
    if (cyc !== LAT || set !== 1'b1 || busy !== 1'b1 || row !== 2'd0 || col !== 2'd0)
      $display("FAIL reset_mid_move: cycle=%0d set=%b busy=%b row=%0d col=%0d, required %0d,1,1,0,0",
               cyc, set, busy, row, col, LAT);
    else passed++;
    board_valid = 9'h001;
    tick(2);
    checks++;
    if (move_count !== 4'd1 || busy !== 1'b0)
      $display("FAIL reset_mid_ack: move_count=%0d busy=%b, required 1 and 0", move_count, busy);
    else passed++;
    btn[4] = 1'b0;
    tick(12);
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_wrap;
    test_legal;
    test_occupied;
    test_game_over;
    test_timeout;
    test_reset_mid;
    checks++;
    if (sbq.size() !== 0)
      $display("FAIL sb_drain: %0d expectations left, required 0", sbq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
